gf2_poly_div_163bit: RTL and testbench

- Sequential bit-serial GF(2)[x] polynomial long divider. It is the inverse operation of the 163-bit Karatsuba carry-less multiplier.
- Takes a 325-bit dividend (a 2N-1 product width) and a 163-bit divisor. Returns quotient and remainder such that dividend = quotient*divisor XOR remainder, with deg(remainder) < deg(divisor).
- Used to check and undo multiplier results, and as a general reducer ahead of field-arithmetic blocks.

---
 rtl/gf2_poly_div_163bit.sv | 134 +++++++++++++
 tb/tb_gf2_poly_div_163bit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_div_163bit.sv
// Bit-serial GF(2)[x] polynomial long divider.
// Computes quotient/remainder with dividend = quotient*divisor XOR remainder,
// deg(remainder) < deg(divisor). The divisor is first normalised so its top
// bit sits at N-1, the division runs MSB-first over the dividend followed by
// s zero bits, and the remainder is then shifted back down by s.
module gf2_poly_div_163bit #(
    parameter int N  = 163,
    parameter int DW = 2 * N - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [N-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [DW-1:0] quotient,
    output logic [N-2:0]  remainder
);

    localparam int SW = $clog2(N);
    localparam int KW = $clog2(DW + N);

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DIV,
        DENORM,
        DONE
    } state_t;

    state_t state, state_next;

    logic [DW-1:0] dv;
    logic [DW-1:0] q;
    logic [N-1:0]  d;
    logic [N-2:0]  r;
    logic [SW-1:0] s;
    logic [KW-1:0] k;
    logic          dz;

    logic [N-1:0]  t;
    logic          q_bit;
    logic [N-1:0]  t_red;

    // One long-division step: bring in the next dividend bit and conditionally cancel the top term.
    always_comb begin
        t     = {r, dv[DW-1]};
        q_bit = t[N-1];
        t_red = t ^ (q_bit ? d : '0);
    end

    // Next-state logic; a zero divisor is flagged at capture and resolved in NORM so it finishes after one step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = NORM;
            NORM: begin
                if (dz)          state_next = DONE;
                else if (d[N-1]) state_next = DIV;
            end
            DIV:     if (k == KW'(1)) state_next = DENORM;
            DENORM:  if (s == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register and datapath; results are published on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dv          <= '0;
            q           <= '0;
            d           <= '0;
            r           <= '0;
            s           <= '0;
            k           <= '0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        dv          <= dividend;
                        d           <= divisor;
                        r           <= '0;
                        q           <= '0;
                        s           <= '0;
                        dz          <= (divisor == '0);
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= (divisor == '0);
                    end
                end
                NORM: begin
                    if (!dz) begin
                        if (d[N-1]) begin
                            k <= KW'(DW) + KW'(s);
                        end else begin
                            d <= {d[N-2:0], 1'b0};
                            s <= s + SW'(1);
                        end
                    end
                end
                DIV: begin
                    r  <= t_red[N-2:0];
                    q  <= {q[DW-2:0], q_bit};
                    dv <= {dv[DW-2:0], 1'b0};
                    k  <= k - KW'(1);
                end
                DENORM: begin
                    if (s == '0) begin
                        quotient  <= q;
                        remainder <= r;
                    end else begin
                        r <= r >> 1;
                        s <= s - SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_poly_div_163bit.sv
// Scoreboard testbench for gf2_poly_div_163bit: stimulus pushes expected
// results, a monitor pops and compares on every done pulse.
module tb_gf2_poly_div_163bit;

    localparam int N  = 163;
    localparam int DW = 2 * N - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [DW-1:0] quotient;
    logic [N-2:0]  remainder;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        int            lat;
        int            c0;
    } exp_t;

    exp_t sb[$];

    gf2_poly_div_163bit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit so the run always ends
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    function automatic int deg_of(input logic [DW-1:0] v);
        int dg = -1;
        for (int i = 0; i < DW; i++) if (v[i]) dg = i;
        return dg;
    endfunction

    // Textbook long division: repeatedly cancel the leading term of the running remainder
    task automatic ref_div(input logic [DW-1:0] a, input logic [N-1:0] b,
                           output logic [DW-1:0] qo, output logic [DW-1:0] ro, output int lat);
        logic [DW-1:0] rem;
        logic [DW-1:0] bx;
        int db;
        int dr;
        qo = '0;
        ro = '0;
        if (b == '0) begin
            lat = 1;
            return;
        end
        bx  = DW'(b);
        db  = deg_of(bx);
        rem = a;
        dr  = deg_of(rem);
        while (dr >= db) begin
            qo[dr - db] = 1'b1;
            rem = rem ^ (bx << (dr - db));
            dr  = deg_of(rem);
        end
        ro  = rem;
        lat = DW + 3 * (N - 1 - db) + 2;
    endtask

    function automatic logic [DW-1:0] clmul(input logic [DW-1:0] a, input logic [N-1:0] b);
        logic [DW-1:0] p = '0;
        for (int i = 0; i < N; i++) if (b[i]) p = p ^ (a << i);
        return p;
    endfunction

    function automatic logic [DW-1:0] rand_poly(input int dg);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < DW; i++) if (i <= dg) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Waits for IDLE, then presents one request and records its expected response
    task automatic apply_stimulus(input logic [DW-1:0] a, input logic [N-1:0] b,
                                  input logic [DW-1:0] eq, input logic [DW-1:0] er, input int lat);
        exp_t e;
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check_output("idle_wait_timeout", 1, 0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.q   = eq;
        e.r   = er;
        e.dz  = (b == '0);
        e.lat = lat;
        e.c0  = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || busy) check_output("drain_timeout", DW'(sb.size()), 0);
    endtask

    // Monitor: every done pulse must match the oldest expected entry and last exactly one cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("quotient", quotient, e.q);
                    check_output("remainder", DW'(remainder), e.r);
                    check_output("div_by_zero", DW'(div_by_zero), DW'(e.dz));
                    check_output("latency", DW'(cyc - e.c0), DW'(e.lat));
                    check_output("busy_at_done", DW'(busy), 1);
                end
                @(negedge clk);
                check_output("done_pulse_width", DW'(done), 0);
                check_output("idle_after_done", DW'(busy), 0);
            end
        end
    end

    initial begin
        logic [DW-1:0] a, r, eq, er, x;
        logic [N-1:0]  b;
        int            lat;
        int            db;
        int            n;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", DW'(busy), 0);
        check_output("reset_done", DW'(done), 0);
        check_output("reset_dz", DW'(div_by_zero), 0);
        check_output("reset_quotient", quotient, 0);
        check_output("reset_remainder", DW'(remainder), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // divisor = 1: maximum normalisation shift
        b = N'(1);
        a = DW'(5);
        apply_stimulus(a, b, DW'(5), '0, 813);
        wait_drain();

        // sparse degree-162 divisor with x^324
        b = '0;
        b[162] = 1'b1; b[7] = 1'b1; b[6] = 1'b1; b[3] = 1'b1; b[0] = 1'b1;
        a = '0;
        a[DW-1] = 1'b1;
        ref_div(a, b, eq, er, lat);
        check_output("model_x324_latency", DW'(lat), DW'(327));
        check_output("model_x324_roundtrip", clmul(eq, b) ^ er, a);
        apply_stimulus(a, b, eq, er, lat);
        wait_drain();

        // zero divisor
        apply_stimulus(rand_poly(DW - 1), '0, '0, '0, 1);
        wait_drain();

        // zero dividend, and dividend of lower degree than the divisor
        b = N'(rand_poly(100));
        b[100] = 1'b1;
        apply_stimulus('0, b, '0, '0, DW + 3 * 62 + 2);
        wait_drain();
        a = rand_poly(99);
        apply_stimulus(a, b, '0, a, DW + 3 * 62 + 2);
        wait_drain();

        // random round trips: dividend = a*b + r
        for (int i = 0; i < 30; i++) begin
            db = $urandom_range(0, N - 1);
            b  = N'(rand_poly(db - 1));
            b[db] = 1'b1;
            r  = rand_poly(db - 1);
            a  = rand_poly(DW - 1 - db);
            x  = clmul(a, b) ^ r;
            apply_stimulus(x, b, a, r, DW + 3 * (N - 1 - db) + 2);
            wait_drain();
        end

        // start held high with changing operands for the whole operation
        b = N'(rand_poly(40));
        b[40] = 1'b1;
        a = rand_poly(DW - 1);
        ref_div(a, b, eq, er, lat);
        apply_stimulus(a, b, eq, er, lat);
        start = 1'b1;
        n = 0;
        while (!done && n < 1000) begin
            dividend = rand_poly(DW - 1);
            divisor  = N'(rand_poly(N - 1));
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        wait_drain();

        // reset during DIV step 100 aborts silently
        b = '0;
        b[162] = 1'b1; b[7] = 1'b1; b[6] = 1'b1; b[3] = 1'b1; b[0] = 1'b1;
        a = rand_poly(DW - 1);
        ref_div(a, b, eq, er, lat);
        apply_stimulus(a, b, eq, er, lat);
        while (cyc < sb[0].c0 + 100) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check_output("abort_busy", DW'(busy), 0);
        check_output("abort_done", DW'(done), 0);
        check_output("abort_dz", DW'(div_by_zero), 0);
        check_output("abort_quotient", quotient, 0);
        check_output("abort_remainder", DW'(remainder), 0);
        apply_stimulus(DW'(6), N'(3), DW'(2), '0, DW + 3 * 161 + 2);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
